// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment constants, font, scroll state and digit helper
package sseg_pkg;
  localparam int SEG_W = 8;
  localparam int DIGITS = 8;
  localparam logic [SEG_W-1:0] BLANK = 8'hFF;
  localparam logic [SEG_W-1:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef enum logic [1:0] {IDLE, RUN, FINISH} scroll_state_e;
  // digit 0 sits in the top byte, digit 7 in the bottom byte
  function automatic logic [SEG_W-1:0] digit_of(input logic [DIGITS*SEG_W-1:0] src, input logic [2:0] idx);
    return src[(DIGITS-1-int'(idx))*SEG_W +: SEG_W];
  endfunction
endpackage

// File: rtl/scroll_tick_gen.sv
// scroll_tick_gen: TICK_DIV prescaler with synchronous clear
// ports: clk, rst_n (async, active-low), clr (sync clear), en (count enable),
//        tc (high in the cycle the counter sits at TICK_DIV-1 while enabled)
module scroll_tick_gen #(
  parameter int TICK_DIV = 2228224
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tc = en && (cnt_q == CW'(TICK_DIV - 1));
    cnt_d = (clr || tc) ? '0 : en ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sseg_scroll_sched.sv
// sseg_scroll_sched: scrolls a message of up to 8 cathode bytes across the display
// ports: clk, rst_n (async, active-low), start, dir (0 left / 1 right),
//        exit (append 8 blank shifts), len (clamped to 8), src (digit 0 in [63:56]),
//        abort; outputs frame, busy, step, done, all registered
module sseg_scroll_sched
  import sseg_pkg::*;
#(
  parameter int TICK_DIV = 2228224
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      dir,
  input  logic                      exit,
  input  logic [3:0]                len,
  input  logic [DIGITS*SEG_W-1:0]   src,
  input  logic                      abort,
  output logic [DIGITS*SEG_W-1:0]   frame,
  output logic                      busy,
  output logic                      step,
  output logic                      done
);
  scroll_state_e state_q, state_d;
  logic [DIGITS*SEG_W-1:0] src_q, src_d, frame_q, frame_d;
  logic [3:0] len_q, len_d;
  logic [4:0] n_q, n_d, k_q, k_d;
  logic dir_q, dir_d, busy_q, busy_d, step_q, step_d, done_q, done_d;
  logic accept, tc;
  logic [2:0] idx;
  logic [SEG_W-1:0] ins;
  // the DONE cycle is not an accepting IDLE cycle
  assign accept = (state_q == IDLE) && start && !done_q;
  scroll_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .clr(accept || abort), .en(state_q == RUN), .tc(tc)
  );
  always_comb begin
    idx = dir_q ? 3'(len_q - 4'd1 - k_q[3:0]) : k_q[2:0];
    ins = (k_q < {1'b0, len_q}) ? digit_of(src_q, idx) : BLANK;
    state_d = state_q;
    src_d = src_q;
    len_d = len_q;
    dir_d = dir_q;
    n_d = n_q;
    k_d = k_q;
    frame_d = frame_q;
    busy_d = busy_q;
    step_d = 1'b0;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      frame_d = '1;
      busy_d = 1'b0;
    end else if (accept) begin
      src_d = src;
      len_d = (len > 4'd8) ? 4'd8 : len;
      dir_d = dir;
      n_d = {1'b0, len_d} + (exit ? 5'd8 : 5'd0);
      k_d = '0;
      frame_d = '1;
      busy_d = (n_d != 5'd0);
      state_d = (n_d == 5'd0) ? FINISH : RUN;
    end else if (state_q == RUN && tc) begin
      frame_d = dir_q ? {ins, frame_q[DIGITS*SEG_W-1:SEG_W]} : {frame_q[(DIGITS-1)*SEG_W-1:0], ins};
      step_d = 1'b1;
      k_d = k_q + 5'd1;
      busy_d = (k_d != n_q);
      state_d = (k_d == n_q) ? FINISH : RUN;
    end else if (state_q == FINISH) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= '0;
      len_q <= '0;
      dir_q <= 1'b0;
      n_q <= '0;
      k_q <= '0;
      frame_q <= '1;
      busy_q <= 1'b0;
      step_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      len_q <= len_d;
      dir_q <= dir_d;
      n_q <= n_d;
      k_q <= k_d;
      frame_q <= frame_d;
      busy_q <= busy_d;
      step_q <= step_d;
      done_q <= done_d;
    end
  assign frame = frame_q;
  assign busy = busy_q;
  assign step = step_q;
  assign done = done_q;
endmodule

// File: tb/tb_sseg_scroll_sched.sv
// tb_sseg_scroll_sched: vector table plus scoreboard of expected frames per shift
module tb_sseg_scroll_sched;
  localparam int TD = 4;
  logic clk = 0, rst_n = 0, start = 0, dir = 0, ex = 0, abort = 0;
  logic [3:0] len = 0;
  logic [63:0] src = 0;
  logic [63:0] frame;
  logic busy, step, done;

  sseg_scroll_sched #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .exit(ex), .len(len),
    .src(src), .abort(abort), .frame(frame), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] f; int dt; } sb_t;
  typedef struct { logic [3:0] len; bit dir; bit ex; logic [63:0] src; int n; logic [63:0] fin; } vec_t;

  sb_t sb[$];
  sb_t e_m;
  vec_t vt[6];
  int cyc = 0, t_start = 0, passed = 0, total = 0, step_cnt = 0;
  bit busy_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] dig(input logic [63:0] s, input int i);
    return s[(7-i)*8 +: 8];
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (busy) busy_seen = 1;
    if (step) begin
      step_cnt++;
      if (sb.size() == 0) chk("sb_unexpected_step", 1, 0);
      else begin
        e_m = sb.pop_front();
        chk("sb_frame", frame, e_m.f);
        chk("sb_step_time", 64'(cyc - t_start), 64'(e_m.dt));
      end
    end
  end

  task automatic go(input logic [3:0] l, input bit d, input bit x, input logic [63:0] s, input bit hold);
    int lc, n;
    logic [63:0] f;
    logic [7:0] ins;
    @(negedge clk);
    len = l; dir = d; ex = x; src = s; start = 1;
    t_start = cyc + 1;
    step_cnt = 0;
    busy_seen = 0;
    lc = (l > 8) ? 8 : int'(l);
    n = lc + (x ? 8 : 0);
    f = '1;
    for (int j = 0; j < n; j++) begin
      ins = (j < lc) ? dig(s, d ? lc - 1 - j : j) : 8'hFF;
      f = d ? {ins, f[63:8]} : {f[55:0], ins};
      sb.push_back('{f, TD * (j + 1)});
    end
    @(negedge clk);
    if (!hold) start = 0;
    src = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string name, input int limit, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        dcyc = cyc;
        chk({name, "_busy_at_done"}, busy, 0);
        break;
      end
      @(negedge clk);
    end
    if (dcyc < 0) chk({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_steps(input int k, input int limit);
    int c = 0;
    for (int i = 0; i < limit && c < k; i++) begin
      @(negedge clk);
      if (step) c++;
    end
    if (c < k) chk("step_timeout", 64'(c), 64'(k));
  endtask

  task automatic run_vec(input int i);
    int dc;
    go(vt[i].len, vt[i].dir, vt[i].ex, vt[i].src, 0);
    wait_done($sformatf("v%0d", i), 200, dc);
    chk($sformatf("v%0d_steps", i), 64'(step_cnt), 64'(vt[i].n));
    chk($sformatf("v%0d_frame", i), frame, vt[i].fin);
    chk($sformatf("v%0d_done_time", i), 64'(dc - t_start), 64'(vt[i].n > 0 ? TD * vt[i].n + 1 : 1));
    chk($sformatf("v%0d_sb_empty", i), 64'(sb.size()), 0);
    if (vt[i].n == 0) chk($sformatf("v%0d_busy_never", i), 64'(busy_seen), 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", i), done, 0);
    chk($sformatf("v%0d_frame_hold", i), frame, vt[i].fin);
  endtask

  initial begin
    int dc, cnt;
    vt[0] = '{4'd4,  0, 0, 64'hF9A4B099_11223344, 4,  64'hFFFFFFFF_F9A4B099};
    vt[1] = '{4'd4,  0, 1, 64'hF9A4B099_11223344, 12, 64'hFFFFFFFF_FFFFFFFF};
    vt[2] = '{4'd2,  1, 0, 64'hC0F90000_00000000, 2,  64'hC0F9FFFF_FFFFFFFF};
    vt[3] = '{4'd12, 0, 0, 64'h01020304_05060708, 8,  64'h01020304_05060708};
    vt[4] = '{4'd0,  0, 0, 64'h12345678_9ABCDEF0, 0,  64'hFFFFFFFF_FFFFFFFF};
    vt[5] = '{4'd3,  1, 1, 64'hC0F9A400_00000000, 11, 64'hFFFFFFFF_FFFFFFFF};
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_frame", frame, 64'hFFFFFFFF_FFFFFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_step", step, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // abort after the 2nd step, with an ignored START in between
    go(4'd4, 0, 0, 64'hF9A4B099_00000000, 0);
    wait_steps(1, 50);
    @(negedge clk);
    start = 1; len = 4'd8; ex = 1;
    @(negedge clk);
    start = 0;
    wait_steps(1, 50);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_frame", frame, 64'hFFFFFFFF_FFFFFFFF);
    chk("abort_busy", busy, 0);
    chk("abort_step", step, 0);
    chk("abort_done", done, 0);
    sb.delete();
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || step) cnt++;
    end
    chk("abort_quiet", 64'(cnt), 0);

    // START held through DONE is accepted one cycle later
    go(4'd1, 0, 0, 64'hAB000000_00000000, 1);
    wait_done("hold", 50, dc);
    chk("hold_done_time", 64'(dc - t_start), 64'(TD + 1));
    chk("hold_frame", frame, 64'hFFFFFFFF_FFFFFFAB);
    @(negedge clk);
    chk("hold_gap_busy", busy, 0);
    @(negedge clk);
    chk("hold_reaccept_busy", busy, 1);
    chk("hold_reaccept_frame", frame, 64'hFFFFFFFF_FFFFFFFF);
    abort = 1; start = 0;
    @(negedge clk);
    abort = 0;
    chk("hold_abort_busy", busy, 0);

    // asynchronous reset mid-scroll
    go(4'd8, 0, 0, 64'h01020304_05060708, 0);
    wait_steps(3, 50);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_frame", frame, 64'hFFFFFFFF_FFFFFFFF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_done", done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    run_vec(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
